// File: rtl/video_scanout.sv
// video_scanout: frame-locked raster fetch from VRAM with vertical scroll and dim.
// Read latency of the VRAM is absorbed by a short shift register so that the
// RGB output and the delayed sync/blank signals leave the block aligned.
module video_scanout #(
  parameter int unsigned H_ACTIVE    = 320,
  parameter int unsigned V_ACTIVE    = 240,
  parameter int unsigned RAM_LATENCY = 2,
  parameter int unsigned ADDR_W      = 17,
  parameter logic [11:0] BORDER_RGB  = 12'h000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce_pix,
  input  logic              hbl,
  input  logic              vbl,
  input  logic              hsync,
  input  logic              vsync,
  input  logic [7:0]        scroll_y,
  input  logic              dim,
  output logic [ADDR_W-1:0] vram_addr,
  input  logic [15:0]       vram_q,
  output logic [11:0]       rgb_out,
  output logic              hbl_o,
  output logic              vbl_o,
  output logic              hsync_o,
  output logic              vsync_o,
  output logic              frame_start,
  output logic              err_long,
  output logic              err_short
);

  // Decoded events for the current clk cycle (all qualified by ce_pix)
  logic              w_frame_start;
  logic              w_line_end;
  logic              w_active;
  logic              w_in_line;
  logic              w_valid;
  logic              w_last_row;
  logic [7:0]        w_sc_next;
  logic [ADDR_W-1:0] w_sc_base;
  logic [11:0]       w_q_rgb;
  logic [11:0]       w_q_dim;
  logic [11:0]       w_pix_next;
  logic              w_unused_q_hi;

  // Raster position and per-frame latches
  logic [8:0]        r_x;
  logic [7:0]        r_row;
  logic [ADDR_W-1:0] r_row_base;
  logic [ADDR_W-1:0] r_vram_addr;
  logic              r_dm;
  logic              r_armed;
  logic              r_vbl_prev;
  logic              r_hbl_prev;
  logic              r_frame_start;
  logic              r_err_long;
  logic              r_err_short;

  // Latency-matching shift registers, index RAM_LATENCY is the oldest stage
  logic [RAM_LATENCY:0] r_valid_sr;
  logic [RAM_LATENCY:0] r_hbl_sr;
  logic [RAM_LATENCY:0] r_vbl_sr;
  logic [RAM_LATENCY:0] r_hs_sr;
  logic [RAM_LATENCY:0] r_vs_sr;

  // Output registers
  logic [11:0]       r_rgb;
  logic              r_hbl_o;
  logic              r_vbl_o;
  logic              r_hs_o;
  logic              r_vs_o;

  // Event decode: frame start on vbl rise, line end on hbl rise outside vblank.
  // Nothing is fetched or counted until a frame start has been seen after reset.
  always_comb begin
    w_frame_start = ce_pix & vbl & ~r_vbl_prev;
    w_line_end    = ce_pix & hbl & ~r_hbl_prev & ~vbl & r_armed;
    w_active      = ce_pix & ~hbl & ~vbl & r_armed;
    w_in_line     = (r_x < 9'(H_ACTIVE));
    w_valid       = w_active & w_in_line;
    w_last_row    = (r_row == 8'(V_ACTIVE - 1));
  end

  // Scroll reduced into 0..V_ACTIVE-1 and the matching row base address
  always_comb begin
    w_sc_next = scroll_y;
    if (scroll_y >= 8'(V_ACTIVE)) begin
      w_sc_next = scroll_y - 8'(V_ACTIVE);
    end
    w_sc_base = ADDR_W'(w_sc_next) * ADDR_W'(H_ACTIVE);
  end

  // Pixel selection at the end of the latency pipe; dim only touches VRAM data
  always_comb begin
    w_q_rgb    = vram_q[11:0];
    w_q_dim    = {1'b0, w_q_rgb[11:9], 1'b0, w_q_rgb[7:5], 1'b0, w_q_rgb[3:1]};
    w_pix_next = BORDER_RGB;
    if (r_valid_sr[RAM_LATENCY] && !r_hbl_sr[RAM_LATENCY] && !r_vbl_sr[RAM_LATENCY]) begin
      w_pix_next = r_dm ? w_q_dim : w_q_rgb;
    end
  end

  // Upper VRAM bits carry no colour information
  assign w_unused_q_hi = ^vram_q[15:12];

  // Raster counters, scroll/dim latches and VRAM address register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x         <= '0;
      r_row       <= '0;
      r_row_base  <= '0;
      r_vram_addr <= '0;
      r_dm        <= 1'b0;
      r_armed     <= 1'b0;
      // Held high so a vbl already high across reset is not taken as a rise
      r_vbl_prev  <= 1'b1;
      r_hbl_prev  <= 1'b1;
    end else if (ce_pix) begin
      r_vbl_prev <= vbl;
      r_hbl_prev <= hbl;
      if (w_frame_start) begin
        r_armed    <= 1'b1;
        r_dm       <= dim;
        r_row      <= w_sc_next;
        r_row_base <= w_sc_base;
        r_x        <= '0;
      end else if (w_valid) begin
        r_vram_addr <= r_row_base + ADDR_W'(r_x);
        r_x         <= r_x + 9'd1;
      end else if (w_line_end) begin
        r_x <= '0;
        // Row base tracks row*H_ACTIVE incrementally, wrapping with the row
        if (w_last_row) begin
          r_row      <= '0;
          r_row_base <= '0;
        end else begin
          r_row      <= r_row + 8'd1;
          r_row_base <= r_row_base + ADDR_W'(H_ACTIVE);
        end
      end
    end
  end

  // Sticky line-length error flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_long  <= 1'b0;
      r_err_short <= 1'b0;
    end else begin
      if (w_active && !w_in_line) begin
        r_err_long <= 1'b1;
      end
      if (w_line_end && (r_x != 9'(H_ACTIVE))) begin
        r_err_short <= 1'b1;
      end
    end
  end

  // Single-clk frame start pulse (w_frame_start already includes ce_pix)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_frame_start;
    end
  end

  // Latency-matching pipe for valid and the raw timing signals
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid_sr <= '0;
      r_hbl_sr   <= '0;
      r_vbl_sr   <= '0;
      r_hs_sr    <= '0;
      r_vs_sr    <= '0;
    end else if (ce_pix) begin
      r_valid_sr <= {r_valid_sr[RAM_LATENCY-1:0], w_valid};
      r_hbl_sr   <= {r_hbl_sr[RAM_LATENCY-1:0], hbl};
      r_vbl_sr   <= {r_vbl_sr[RAM_LATENCY-1:0], vbl};
      r_hs_sr    <= {r_hs_sr[RAM_LATENCY-1:0], hsync};
      r_vs_sr    <= {r_vs_sr[RAM_LATENCY-1:0], vsync};
    end
  end

  // Output register: pixel and timing leave together
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rgb   <= '0;
      r_hbl_o <= 1'b1;
      r_vbl_o <= 1'b1;
      r_hs_o  <= 1'b0;
      r_vs_o  <= 1'b0;
    end else if (ce_pix) begin
      r_rgb   <= w_pix_next;
      r_hbl_o <= r_hbl_sr[RAM_LATENCY];
      r_vbl_o <= r_vbl_sr[RAM_LATENCY];
      r_hs_o  <= r_hs_sr[RAM_LATENCY];
      r_vs_o  <= r_vs_sr[RAM_LATENCY];
    end
  end

  assign vram_addr   = r_vram_addr;
  assign rgb_out     = r_rgb;
  assign hbl_o       = r_hbl_o;
  assign vbl_o       = r_vbl_o;
  assign hsync_o     = r_hs_o;
  assign vsync_o     = r_vs_o;
  assign frame_start = r_frame_start;
  assign err_long    = r_err_long;
  assign err_short   = r_err_short;

endmodule

// File: tb/tb_video_scanout.sv
// tb_video_scanout: randomized raster stimulus with ce_pix gaps, checked every clk
// against a frame/line/pixel reference model and a VRAM with fixed read latency.
`timescale 1ns/1ps
module tb_video_scanout;

  localparam int          H      = 16;
  localparam int          V      = 12;
  localparam int          L      = 2;
  localparam int          AW     = 17;
  localparam int          HB     = 4;
  localparam int          VB     = 2;
  localparam logic [11:0] BORDER = 12'hA5C;

  typedef struct packed {
    logic [11:0] rgb;
    logic        h;
    logic        v;
    logic        hs;
    logic        vs;
  } pix_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          ce_pix;
  logic          hbl, vbl, hsync, vsync, dim;
  logic [7:0]    scroll_y;
  logic [AW-1:0] vram_addr;
  logic [15:0]   vram_q;
  logic [11:0]   rgb_out;
  logic          hbl_o, vbl_o, hsync_o, vsync_o, frame_start, err_long, err_short;

  logic [15:0] mem [0:(1<<AW)-1];
  logic [15:0] ram_pipe [0:L-1];

  int   checks;
  int   failures;

  // Reference model state
  bit            m_armed;
  bit            m_dm;
  int            m_sc;
  int            m_line;
  int            m_pix;
  logic          m_vbl_prev;
  logic          m_hbl_prev;
  logic [AW-1:0] m_addr;
  logic          m_err_long;
  logic          m_err_short;
  logic          exp_fs;
  pix_t          exp_p;
  pix_t          pq[$];

  video_scanout #(
    .H_ACTIVE   (H),
    .V_ACTIVE   (V),
    .RAM_LATENCY(L),
    .ADDR_W     (AW),
    .BORDER_RGB (BORDER)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .ce_pix     (ce_pix),
    .hbl        (hbl),
    .vbl        (vbl),
    .hsync      (hsync),
    .vsync      (vsync),
    .scroll_y   (scroll_y),
    .dim        (dim),
    .vram_addr  (vram_addr),
    .vram_q     (vram_q),
    .rgb_out    (rgb_out),
    .hbl_o      (hbl_o),
    .vbl_o      (vbl_o),
    .hsync_o    (hsync_o),
    .vsync_o    (vsync_o),
    .frame_start(frame_start),
    .err_long   (err_long),
    .err_short  (err_short)
  );

  always #5 clk = ~clk;

  // VRAM: data for an address registered on tick N is on vram_q after tick N+L
  always @(posedge clk) begin
    if (ce_pix) begin
      ram_pipe[0] <= mem[vram_addr];
      for (int i = 1; i < L; i++) ram_pipe[i] <= ram_pipe[i-1];
    end
  end
  assign vram_q = ram_pipe[L-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] dimmed(input logic [11:0] d);
    return {d[11:8] >> 1, d[7:4] >> 1, d[3:0] >> 1};
  endfunction

  task automatic model_reset();
    pix_t e;
    m_armed     = 1'b0;
    m_dm        = 1'b0;
    m_sc        = 0;
    m_line      = 0;
    m_pix       = 0;
    m_vbl_prev  = 1'b1;
    m_hbl_prev  = 1'b1;
    m_addr      = '0;
    m_err_long  = 1'b0;
    m_err_short = 1'b0;
    exp_fs      = 1'b0;
    exp_p       = '0;
    exp_p.h     = 1'b1;
    exp_p.v     = 1'b1;
    pq.delete();
    e     = '0;
    e.rgb = BORDER;
    repeat (L + 1) pq.push_back(e);
  endtask

  // One ce tick of the model: what gets fetched and what leaves L+1 ticks later
  task automatic model_step(input logic h, input logic v, input logic hs, input logic vs);
    bit          fs, le, act;
    pix_t        e;
    int          a;
    logic [11:0] d;
    fs    = v && !m_vbl_prev;
    le    = h && !m_hbl_prev && !v;
    act   = !h && !v;
    e     = '0;
    e.rgb = BORDER;
    e.h   = h;
    e.v   = v;
    e.hs  = hs;
    e.vs  = vs;
    if (fs) begin
      m_armed = 1'b1;
      m_sc    = (int'(scroll_y) >= V) ? int'(scroll_y) - V : int'(scroll_y);
      m_dm    = dim;
      m_line  = 0;
      m_pix   = 0;
    end else if (m_armed && act) begin
      if (m_pix < H) begin
        a      = ((m_sc + m_line) % V) * H + m_pix;
        m_addr = AW'(a);
        d      = mem[a][11:0];
        e.rgb  = m_dm ? dimmed(d) : d;
        m_pix++;
      end else begin
        m_err_long = 1'b1;
      end
    end else if (m_armed && le) begin
      if (m_pix != H) m_err_short = 1'b1;
      m_line++;
      m_pix = 0;
    end
    m_vbl_prev = v;
    m_hbl_prev = h;
    exp_fs     = fs;
    pq.push_back(e);
    exp_p = pq.pop_front();
  endtask

  task automatic check_outputs();
    check("vram_addr", 32'(vram_addr), 32'(m_addr));
    check("rgb_out", 32'(rgb_out), 32'(exp_p.rgb));
    check("hbl_o", 32'(hbl_o), 32'(exp_p.h));
    check("vbl_o", 32'(vbl_o), 32'(exp_p.v));
    check("hsync_o", 32'(hsync_o), 32'(exp_p.hs));
    check("vsync_o", 32'(vsync_o), 32'(exp_p.vs));
    check("frame_start", 32'(frame_start), 32'(exp_fs));
    check("err_long", 32'(err_long), 32'(m_err_long));
    check("err_short", 32'(err_short), 32'(m_err_short));
  endtask

  // One pixel tick, preceded by 0..2 clk cycles with ce_pix low and junk inputs
  task automatic tick(input logic h, input logic v, input logic hs, input logic vs);
    int gap;
    gap = $urandom_range(0, 2);
    for (int i = 0; i < gap; i++) begin
      ce_pix = 1'b0;
      hbl    = 1'($urandom);
      vbl    = 1'($urandom);
      hsync  = 1'($urandom);
      vsync  = 1'($urandom);
      @(negedge clk);
      exp_fs = 1'b0;
      check_outputs();
    end
    hbl    = h;
    vbl    = v;
    hsync  = hs;
    vsync  = vs;
    ce_pix = 1'b1;
    model_step(h, v, hs, vs);
    @(negedge clk);
    ce_pix = 1'b0;
    check_outputs();
  endtask

  task automatic drive_line(input int n_act, input logic v, input logic vs, input logic v_hb);
    for (int i = 0; i < n_act; i++) tick(1'b0, v, 1'b0, vs);
    for (int i = 0; i < HB; i++) tick(1'b1, v_hb, (i == 1 || i == 2), vs);
  endtask

  // Frame begins with the vbl rise; both_rise raises vbl together with the last hbl
  task automatic run_frame(input int long_ln, input int short_ln, input bit both_rise);
    int n;
    for (int l = 0; l < VB; l++) drive_line(H, 1'b1, (l == 0), 1'b1);
    for (int l = 0; l < V; l++) begin
      n = (l == long_ln) ? H + 2 : (l == short_ln) ? H - 2 : H;
      if (l == V / 2) begin
        scroll_y = 8'($urandom_range(0, 2 * V - 1));
        dim      = 1'($urandom);
      end
      if (both_rise && l == V - 1) dim = m_dm;
      drive_line(n, 1'b0, 1'b0, both_rise && (l == V - 1));
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    ce_pix   = 1'b0;
    hbl      = 1'b1;
    vbl      = 1'b1;
    hsync    = 1'b0;
    vsync    = 1'b0;
    scroll_y = 8'd0;
    dim      = 1'b0;
    for (int i = 0; i < H * V; i++) mem[i] = 16'($urandom);
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    reset = 1'b0;

    // Activity before the first vbl rise must produce border only
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < HB; i++) tick(1'b1, 1'b0, 1'b0, 1'b0);

    run_frame(-1, -1, 1'b0);
    run_frame(-1, -1, 1'b0);
    run_frame(3, -1, 1'b0);
    run_frame(-1, 5, 1'b0);
    run_frame(-1, -1, 1'b1);
    run_frame(2, 7, 1'b0);

    // Reset in the middle of a line
    for (int l = 0; l < VB; l++) drive_line(H, 1'b1, (l == 0), 1'b1);
    for (int l = 0; l < 5; l++) drive_line(H, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_outputs();
    hbl = 1'b0;
    vbl = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs();
    reset = 1'b0;
    for (int i = 7; i < H; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < HB; i++) tick(1'b1, 1'b0, 1'b0, 1'b0);
    run_frame(-1, -1, 1'b0);
    run_frame(-1, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/video_scanout.md
# video_scanout

Pixel fetch stage between the CPU-written VRAM (dual-port, read port B) and `arcade_video`. It walks VRAM in raster order using the `video_timing` blanking signals, with an optional vertical scroll and a dim mode. It compensates the VRAM read latency and emits 12-bit RGB together with sync and blank delayed to match. It replaces the free-running `vramAddr` counter with frame-locked addressing and error detection.

## Interface

Parameters:
- `H_ACTIVE`, 320, visible pixels per line.
- `V_ACTIVE`, 240, visible lines per frame; must be ≤ 255.
- `RAM_LATENCY`, 2, ce_pix ticks from `vram_addr` registered to `vram_q` valid; range 1–4.
- `ADDR_W`, 17, VRAM word address width.
- `BORDER_RGB`, 12'h000, colour driven for blanked or invalid pixels.

Ports (clock and reset first):
- `clk`, in, 1: system clock (clk_sys).
- `reset`, in, 1: asynchronous, active-high.
- `ce_pix`, in, 1: pixel clock enable; all state advances only on `clk` edges with `ce_pix`=1.
- `hbl`, `vbl`, `hsync`, `vsync`, in, 1 each: raw timing from `video_timing`.
- `scroll_y`, in, 8: vertical scroll in lines, sampled at frame start.
- `dim`, in, 1: halve output brightness, sampled at frame start.
- `vram_addr`, out, ADDR_W: VRAM read address.
- `vram_q`, in, 16: VRAM read data; bits [11:0] are RGB444.
- `rgb_out`, out, 12: pixel to `arcade_video`.
- `hbl_o`, `vbl_o`, `hsync_o`, `vsync_o`, out, 1 each: timing delayed to align with `rgb_out`.
- `frame_start`, out, 1: one-`clk` pulse on the frame-start tick.
- `err_long`, `err_short`, out, 1 each: sticky line-length errors.

## Operation

Counters:
- `x`: 9-bit.
- `row`: 8-bit, in 0..V_ACTIVE-1.
- `row_base`: ADDR_W-bit, always equal to `row`×H_ACTIVE.
- Scroll and dim latches: `sc`, `dm`.

Frame start is a ce tick with `vbl`=1 while the `vbl` sampled on the previous tick was 0. On that tick:
- `sc` is set to `scroll_y`, reduced by one conditional subtraction of V_ACTIVE if `scroll_y` ≥ V_ACTIVE.
- `row` is set to `sc`, `row_base` to `sc`×H_ACTIVE, and `x` to 0.
- `dm` is set to `dim`.
- `frame_start` is pulsed.

Active tick (`hbl`=0, `vbl`=0):
- If `x` < H_ACTIVE: `vram_addr` is set to `row_base`+`x`, `valid`=1, and `x` increments.
- Otherwise: `vram_addr` holds, `valid`=0, `err_long` is set, and `x` saturates.

Line end is a ce tick with `hbl` rising while `vbl`=0:
- If `x` ≠ H_ACTIVE, set `err_short`; this includes `x`=0.
- Set `x` to 0.
- Advance the row: if `row`=V_ACTIVE-1, set `row` and `row_base` to 0; otherwise increment `row` and add H_ACTIVE to `row_base`. No multiplier is used here.

Blank ticks other than those above hold the counters.

Output pipeline:
- `valid`, `hbl`, `vbl`, `hsync` and `vsync` pass through a shift register of depth RAM_LATENCY+1 ce ticks.
- The output register captures `vram_q` when the delayed `valid` is 1 and the delayed blank is 0. Otherwise it captures BORDER_RGB.
- When `dm`=1, each 4-bit channel is shifted right by 1 (12'hFFF becomes 12'h777). Dim applies to VRAM data only, not to BORDER_RGB.

Error flags:
- `err_long` and `err_short` clear only on `reset`.
- Both flags may set on the same line.

Boundary behaviour:
- Scroll wrap: row V_ACTIVE-1 is followed by row 0 within the same frame.
- Changing `scroll_y` or `dim` mid-frame has no effect until the next frame start.
- Frame start and line end on the same tick (`hbl` and `vbl` both rising): frame start wins, and `row` is not advanced.
- `reset` mid-line: all state clears immediately. The first complete frame is valid only after the next `vbl` rising edge. Until then, `valid`=0 and BORDER_RGB is output.

## Timing

Reset values:
- `vram_addr`=0, `rgb_out`=0.
- `hbl_o`=1, `vbl_o`=1, `hsync_o`=0, `vsync_o`=0.
- `frame_start`=0, `err_long`=0, `err_short`=0.
- `x`, `row`, `row_base`, `sc`, `dm` and the pipeline are all 0. The previous-`vbl` register resets to 1, so no frame start occurs while `vbl` is held across reset.

Latency:
- A pixel sampled active at ce tick N appears on `rgb_out` at tick N+RAM_LATENCY+1.
- `hbl_o`, `vbl_o`, `hsync_o` and `vsync_o` carry identical delay.

Other timing:
- `vram_addr` changes only on ce ticks and is stable between them.
- `frame_start` is high for exactly one `clk` cycle, coincident with the ce tick.
- Outputs change only on ce ticks, except for the asynchronous reset.

## Test plan

- Nominal frame: 320×240 timing, VRAM word at address A holds A[11:0], `scroll_y`=0. Line 0 `rgb_out` reads 000, 001, … 13F. Line 1 pixel 0 reads 140 (address 320). Output lags `hbl` by exactly 3 ticks (RAM_LATENCY=2). No errors.
- Scroll: `scroll_y`=10. Line 0 pixel 0 address is 3200. Line 229 fetches row 239 (address 76480). Line 230 fetches address 0. `scroll_y`=250 behaves identically to 10.
- Dim and latch timing: `dim` is raised mid-frame with VRAM = 12'hFFF. Output stays FFF until the next `vbl` rise, then reads 777. Blanked pixels remain BORDER_RGB.
- Long line: drive 322 active ticks on one line. The last 2 pixels are BORDER_RGB, `vram_addr` holds at `row_base`+319, `err_long`=1 and stays set for following frames.
- Short line: drive 318 active ticks. `err_short`=1, and the next line still starts at `row_base`+320.
- Reset mid-line: assert `reset` at pixel 100 of line 50. All outputs take reset values immediately. After release, `rgb_out` stays BORDER_RGB until the first `frame_start`. The following frame matches the nominal case.
